// File: rtl/inst_buffer_pkg.sv
// Shared NPU instruction-path definitions.
// Holds the instruction geometry (128-bit lines split into four 32-bit
// lanes, 12-bit line address) and the lane index constants used by the
// instruction buffer and its host-side address decoding.
package inst_buffer_pkg;

  localparam int INST_DW     = 128;
  localparam int INST_AW     = 12;
  localparam int INST_LANES  = 4;
  localparam int INST_LANE_W = INST_DW / INST_LANES;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Picks one 32-bit lane out of an instruction line; lane 0 is bits 31:0.
  function automatic logic [INST_LANE_W-1:0] laneWord(
    input logic [INST_DW-1:0] line,
    input logic [1:0]         lane
  );
    logic [INST_LANE_W-1:0] word;
    case (lane)
      LANE0:   word = line[31:0];
      LANE1:   word = line[63:32];
      LANE2:   word = line[95:64];
      default: word = line[127:96];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/inst_buffer_ram.sv
// Simple dual-port instruction RAM: one synchronous write port, one
// synchronous read port with a registered output and no reset, so it maps
// directly onto a memory macro.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr     read port (data appears the cycle after i_re)
//   o_rdata          registered read data, holds when i_re is low
module inst_ram_sdp #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 128
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Plain read-old-data array; the buffer above handles write-first bypass
  // so this block can be replaced by a vendor macro unchanged.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer feeding the instruction controller.
// The host loads each 128-bit instruction as four 32-bit lane writes: lanes
// 0-2 are staged, the lane-3 write commits the whole line to RAM. The
// controller fetches one line per request with one-cycle latency; fetches
// beyond the loaded program return zero with o_pc_err. Host access is only
// honoured while the NPU is idle.
// Ports:
//   i_clk, i_rst                    clock, async active-high reset
//   i_host_wr_en/addr/wdata         host lane write, addr = {line, lane}
//   i_host_rd_en, o_host_rdata/rvalid   host lane read-back
//   o_host_wr_err                   pulse on rejected or incomplete write
//   i_npu_idle                      host access allowed when high
//   i_pc, i_rd_en                   controller fetch request
//   o_inst, o_inst_valid, o_pc_err  fetch result
//   o_loaded_lines                  highest committed line + 1
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = INST_AW,
  parameter int DW    = INST_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_host_wr_en,
  input  logic [AW+1:0] i_host_addr,
  input  logic [31:0]   i_host_wdata,
  input  logic          i_host_rd_en,
  output logic [31:0]   o_host_rdata,
  output logic          o_host_rvalid,
  output logic          o_host_wr_err,
  input  logic          i_npu_idle,
  input  logic [AW-1:0] i_pc,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_inst,
  output logic          o_inst_valid,
  output logic          o_pc_err,
  output logic [AW:0]   o_loaded_lines
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [31:0]   r_stg0, r_stg1, r_stg2;
  logic [2:0]    r_laneMask;
  logic          r_wrErr;
  logic [AW:0]   r_loaded;
  logic          r_fetchValid, r_fetchErr;
  logic [DW-1:0] r_instHold;
  logic          r_hostRvalid, r_hostZero;
  logic [1:0]    r_hostLane;
  logic          r_pendValid;
  logic [AW+1:0] r_pendAddr;
  logic          r_bypass;
  logic [DW-1:0] r_bypassData;

  logic [AW-1:0] w_hostLine;
  logic [1:0]    w_hostLane;
  logic          w_hostLineOk, w_wrAccept, w_commit, w_wrErr;
  logic [DW-1:0] w_commitData;
  logic [AW:0]   w_lineInc, w_loadedNext;
  logic          w_pcBad;
  logic          w_hostRdOk, w_pendService, w_hostRdDirect, w_hostRdZero, w_pendSet;
  logic [AW-1:0] w_ramRaddr;
  logic          w_ramRe;
  logic [DW-1:0] w_ramRdata, w_rdData, w_instNow;

  assign w_hostLine   = i_host_addr[AW+1:2];
  assign w_hostLane   = i_host_addr[1:0];
  assign w_hostLineOk = ({1'b0, w_hostLine} < DEPTH_L);

  // Lane-3 always commits when accepted, even with lanes missing, so the
  // host sees an error but the line still lands in RAM with stale lanes.
  assign w_wrAccept   = i_host_wr_en & i_npu_idle & w_hostLineOk;
  assign w_commit     = w_wrAccept & (w_hostLane == LANE3);
  assign w_wrErr      = i_host_wr_en &
                        (~i_npu_idle | ~w_hostLineOk |
                         ((w_hostLane == LANE3) & (r_laneMask != 3'b111)));
  assign w_commitData = {i_host_wdata, r_stg2, r_stg1, r_stg0};

  assign w_lineInc    = {1'b0, w_hostLine} + (AW+1)'(1);
  assign w_loadedNext = (w_commit && (w_lineInc > r_loaded)) ? w_lineInc : r_loaded;

  // The bound check uses the post-commit line count so a fetch racing the
  // commit of a brand-new line sees it, matching the write-first bypass.
  assign w_pcBad = ({1'b0, i_pc} >= DEPTH_L) | ({1'b0, i_pc} >= w_loadedNext);

  // Host reads share the RAM read port; fetches win, a blocked host read
  // parks in a single pending slot, and reads that can never be served
  // return zero immediately so the host is never stalled.
  assign w_hostRdOk     = i_npu_idle & w_hostLineOk;
  assign w_pendService  = r_pendValid & ~i_rd_en;
  assign w_hostRdDirect = i_host_rd_en & w_hostRdOk & ~i_rd_en & ~r_pendValid;
  assign w_hostRdZero   = i_host_rd_en & ~w_hostRdOk & ~r_pendValid;
  assign w_pendSet      = i_host_rd_en & w_hostRdOk & i_rd_en & ~r_pendValid;

  assign w_ramRaddr = i_rd_en     ? i_pc :
                      r_pendValid ? r_pendAddr[AW+1:2] : w_hostLine;
  assign w_ramRe    = (i_rd_en & ~w_pcBad) | w_pendService | w_hostRdDirect;

  inst_ram_sdp #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_commit),
    .i_waddr (w_hostLine),
    .i_wdata (w_commitData),
    .i_re    (w_ramRe),
    .i_raddr (w_ramRaddr),
    .o_rdata (w_ramRdata)
  );

  assign w_rdData  = r_bypass ? r_bypassData : w_ramRdata;
  assign w_instNow = r_fetchErr ? '0 : w_rdData;

  // Host write path: lane staging, lane mask, error pulse and line count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stg0     <= '0;
      r_stg1     <= '0;
      r_stg2     <= '0;
      r_laneMask <= '0;
      r_wrErr    <= 1'b0;
      r_loaded   <= '0;
    end else begin
      r_wrErr  <= w_wrErr;
      r_loaded <= w_loadedNext;
      if (w_commit) begin
        r_laneMask <= '0;
      end else if (w_wrAccept) begin
        case (w_hostLane)
          LANE0: begin r_stg0 <= i_host_wdata; r_laneMask[0] <= 1'b1; end
          LANE1: begin r_stg1 <= i_host_wdata; r_laneMask[1] <= 1'b1; end
          LANE2: begin r_stg2 <= i_host_wdata; r_laneMask[2] <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // Fetch result pipeline; the hold register keeps o_inst stable between
  // valid pulses even though the RAM output moves with host reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetchValid <= 1'b0;
      r_fetchErr   <= 1'b0;
      r_instHold   <= '0;
    end else begin
      r_fetchValid <= i_rd_en;
      r_fetchErr   <= i_rd_en & w_pcBad;
      if (r_fetchValid) begin
        r_instHold <= w_instNow;
      end
    end
  end

  // Host read pipeline and the single pending-read slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hostRvalid <= 1'b0;
      r_hostZero   <= 1'b0;
      r_hostLane   <= '0;
      r_pendValid  <= 1'b0;
      r_pendAddr   <= '0;
    end else begin
      r_hostRvalid <= w_pendService | w_hostRdDirect | w_hostRdZero;
      r_hostZero   <= w_hostRdZero;
      r_hostLane   <= r_pendValid ? r_pendAddr[1:0] : w_hostLane;
      if (w_pendService) begin
        r_pendValid <= 1'b0;
      end else if (w_pendSet) begin
        r_pendValid <= 1'b1;
        r_pendAddr  <= i_host_addr;
      end
    end
  end

  // Write-first bypass: when a commit hits the line being read this cycle,
  // the freshly written data replaces the RAM's old-data output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bypass     <= 1'b0;
      r_bypassData <= '0;
    end else begin
      r_bypass <= w_commit & w_ramRe & (w_hostLine == w_ramRaddr);
      if (w_commit) begin
        r_bypassData <= w_commitData;
      end
    end
  end

  assign o_inst         = r_fetchValid ? w_instNow : r_instHold;
  assign o_inst_valid   = r_fetchValid;
  assign o_pc_err       = r_fetchValid & r_fetchErr;
  assign o_host_rvalid  = r_hostRvalid;
  assign o_host_rdata   = (r_hostRvalid && !r_hostZero) ? laneWord(w_rdData, r_hostLane) : '0;
  assign o_host_wr_err  = r_wrErr;
  assign o_loaded_lines = r_loaded;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed scoreboard bench for inst_buffer. Each applyStimulus call drives
// one cycle of inputs, updates a behavioural model of the buffer and queues
// the fetch / host-read results the DUT owes; checkOutput pops and compares
// them one cycle later.
module tb_inst_buffer;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_host_wr_en;
  logic [13:0]   i_host_addr;
  logic [31:0]   i_host_wdata;
  logic          i_host_rd_en;
  logic [31:0]   o_host_rdata;
  logic          o_host_rvalid;
  logic          o_host_wr_err;
  logic          i_npu_idle;
  logic [11:0]   i_pc;
  logic          i_rd_en;
  logic [127:0]  o_inst;
  logic          o_inst_valid;
  logic          o_pc_err;
  logic [12:0]   o_loaded_lines;

  inst_buffer dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_host_wr_en   (i_host_wr_en),
    .i_host_addr    (i_host_addr),
    .i_host_wdata   (i_host_wdata),
    .i_host_rd_en   (i_host_rd_en),
    .o_host_rdata   (o_host_rdata),
    .o_host_rvalid  (o_host_rvalid),
    .o_host_wr_err  (o_host_wr_err),
    .i_npu_idle     (i_npu_idle),
    .i_pc           (i_pc),
    .i_rd_en        (i_rd_en),
    .o_inst         (o_inst),
    .o_inst_valid   (o_inst_valid),
    .o_pc_err       (o_pc_err),
    .o_loaded_lines (o_loaded_lines)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [127:0] inst;
    logic         err;
  } fetch_t;

  fetch_t       fetchQ[$];
  logic [31:0]  hostQ[$];

  logic [127:0] mMem [4096];
  logic [31:0]  mStg [4];
  logic [2:0]   mMask;
  logic [12:0]  mLoaded;
  logic         mPend;
  logic [13:0]  mPendAddr;
  logic         expFetch, expHost, expErr;
  logic [127:0] lastInst;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] laneOf(input logic [127:0] d, input logic [1:0] lane);
    return d[lane*32 +: 32];
  endfunction

  function automatic logic [127:0] readModel(input logic [11:0] rline, input logic commit,
                                             input logic [11:0] wline, input logic [127:0] cdata);
    return (commit && (wline == rline)) ? cdata : mMem[rline];
  endfunction

  task automatic resetModel();
    fetchQ.delete();
    hostQ.delete();
    for (int i = 0; i < 4; i++) mStg[i] = '0;
    mMask    = '0;
    mLoaded  = '0;
    mPend    = 1'b0;
    mPendAddr = '0;
    expFetch = 1'b0;
    expHost  = 1'b0;
    expErr   = 1'b0;
    lastInst = '0;
  endtask

  task automatic checkOutput();
    fetch_t f;
    chk("fetch_valid", o_inst_valid, expFetch);
    if (o_inst_valid === 1'b1) begin
      chk("fetch_q_nonempty", (fetchQ.size() != 0), 1'b1);
      if (fetchQ.size() != 0) begin
        f = fetchQ.pop_front();
        chk("fetch_inst", o_inst, f.inst);
        chk("fetch_pc_err", o_pc_err, f.err);
        lastInst = f.inst;
      end
    end else begin
      chk("inst_hold", o_inst, lastInst);
      chk("pc_err_quiet", o_pc_err, 1'b0);
    end
    chk("host_rvalid", o_host_rvalid, expHost);
    if (o_host_rvalid === 1'b1) begin
      chk("host_q_nonempty", (hostQ.size() != 0), 1'b1);
      if (hostQ.size() != 0) chk("host_rdata", o_host_rdata, hostQ.pop_front());
    end
    chk("wr_err", o_host_wr_err, expErr);
    chk("loaded_lines", o_loaded_lines, mLoaded);
  endtask

  task automatic applyStimulus(input logic wr, input logic [13:0] addr, input logic [31:0] wdata,
                               input logic hrd, input logic rd, input logic [11:0] pc,
                               input logic idle);
    logic [11:0]  line;
    logic [1:0]   lane;
    logic         commit;
    logic [127:0] cdata;
    logic [12:0]  newLoaded;
    i_host_wr_en = wr;
    i_host_addr  = addr;
    i_host_wdata = wdata;
    i_host_rd_en = hrd;
    i_rd_en      = rd;
    i_pc         = pc;
    i_npu_idle   = idle;
    line   = addr[13:2];
    lane   = addr[1:0];
    commit = wr && idle && (lane == 2'd3);
    cdata  = {wdata, mStg[2], mStg[1], mStg[0]};
    expErr = wr && (!idle || ((lane == 2'd3) && (mMask != 3'b111)));
    newLoaded = mLoaded;
    if (commit && (({1'b0, line} + 13'd1) > mLoaded)) newLoaded = {1'b0, line} + 13'd1;
    expFetch = rd;
    if (rd) begin
      if ({1'b0, pc} >= newLoaded) fetchQ.push_back('{inst: 128'h0, err: 1'b1});
      else fetchQ.push_back('{inst: readModel(pc, commit, line, cdata), err: 1'b0});
    end
    expHost = 1'b0;
    if (mPend) begin
      if (!rd) begin
        hostQ.push_back(laneOf(readModel(mPendAddr[13:2], commit, line, cdata), mPendAddr[1:0]));
        expHost = 1'b1;
        mPend   = 1'b0;
      end
    end else if (hrd) begin
      if (!idle) begin
        hostQ.push_back(32'h0);
        expHost = 1'b1;
      end else if (rd) begin
        mPend     = 1'b1;
        mPendAddr = addr;
      end else begin
        hostQ.push_back(laneOf(readModel(line, commit, line, cdata), lane));
        expHost = 1'b1;
      end
    end
    if (wr && idle) begin
      if (lane == 2'd3) begin
        mMem[line] = cdata;
        mMask      = '0;
      end else begin
        mStg[lane]  = wdata;
        mMask[lane] = 1'b1;
      end
    end
    mLoaded = newLoaded;
    @(posedge i_clk);
    #1;
    checkOutput();
  endtask

  task automatic hostWrite(input logic [11:0] line, input logic [1:0] lane, input logic [31:0] d);
    applyStimulus(1'b1, {line, lane}, d, 1'b0, 1'b0, 12'd0, 1'b1);
  endtask

  task automatic fetch(input logic [11:0] pc);
    applyStimulus(1'b0, 14'd0, 32'd0, 1'b0, 1'b1, pc, 1'b1);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 12'd0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mMem[i] = '0;
    resetModel();
    i_rst = 1'b1;
    i_host_wr_en = 1'b0;
    i_host_addr  = '0;
    i_host_wdata = '0;
    i_host_rd_en = 1'b0;
    i_npu_idle   = 1'b1;
    i_pc         = '0;
    i_rd_en      = 1'b0;
    #1;
    checkOutput();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idleCycle();

    // Lines 0-3, back-to-back fetches, then a fetch past the program end.
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 4; k++)
        hostWrite(12'(l), 2'(k), 32'hA000_0000 + 32'(l * 256 + k));
    for (int p = 0; p < 5; p++) fetch(12'(p));
    chk("pc4_err_const", o_pc_err, 1'b1);
    idleCycle();

    // Line 5 load and fetch.
    hostWrite(12'd5, 2'd0, 32'h11111111);
    hostWrite(12'd5, 2'd1, 32'h22222222);
    hostWrite(12'd5, 2'd2, 32'h33333333);
    hostWrite(12'd5, 2'd3, 32'h44444444);
    fetch(12'd5);
    chk("line5_const", o_inst, 128'h44444444_33333333_22222222_11111111);
    chk("loaded6_const", o_loaded_lines, 13'd6);

    // Write while busy is rejected; old line 0 still fetched.
    applyStimulus(1'b1, {12'd0, 2'd0}, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 14'd0, 32'd0, 1'b0, 1'b1, 12'd0, 1'b0);

    // Incomplete line 6: lane 3 after lanes 0,1 commits stale lane 2 with error.
    hostWrite(12'd6, 2'd0, 32'h66660000);
    hostWrite(12'd6, 2'd1, 32'h66661111);
    hostWrite(12'd6, 2'd3, 32'h66663333);
    fetch(12'd6);

    // Commit of line 7 racing a fetch of line 7.
    hostWrite(12'd7, 2'd0, 32'h77770000);
    hostWrite(12'd7, 2'd1, 32'h77771111);
    hostWrite(12'd7, 2'd2, 32'h77772222);
    applyStimulus(1'b1, {12'd7, 2'd3}, 32'h77773333, 1'b0, 1'b1, 12'd7, 1'b1);
    chk("bypass_const", o_inst, 128'h77773333_77772222_77771111_77770000);

    // Host reads: direct, delayed by a fetch, dropped while pending, busy.
    applyStimulus(1'b0, {12'd5, 2'd0}, 32'd0, 1'b1, 1'b0, 12'd0, 1'b1);
    chk("host_direct_const", o_host_rdata, 32'h11111111);
    applyStimulus(1'b0, {12'd5, 2'd2}, 32'd0, 1'b1, 1'b1, 12'd1, 1'b1);
    applyStimulus(1'b0, {12'd5, 2'd1}, 32'd0, 1'b1, 1'b0, 12'd0, 1'b1);
    chk("host_pending_const", o_host_rdata, 32'h33333333);
    applyStimulus(1'b0, {12'd5, 2'd3}, 32'd0, 1'b1, 1'b1, 12'd1, 1'b1);
    fetch(12'd2);
    idleCycle();
    applyStimulus(1'b0, {12'd5, 2'd3}, 32'd0, 1'b1, 1'b0, 12'd0, 1'b0);
    idleCycle();

    // Reset during a fetch with two lanes staged.
    hostWrite(12'd0, 2'd0, 32'hBBBB0000);
    hostWrite(12'd0, 2'd1, 32'hBBBB1111);
    fetch(12'd3);
    i_rd_en = 1'b1;
    i_pc    = 12'd1;
    #2;
    i_rst = 1'b1;
    #1;
    resetModel();
    checkOutput();
    i_rd_en = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput();
    i_rst = 1'b0;
    hostWrite(12'd0, 2'd3, 32'hCCCC3333);
    chk("post_reset_err_const", o_host_wr_err, 1'b1);
    chk("post_reset_loaded_const", o_loaded_lines, 13'd1);
    fetch(12'd0);
    fetch(12'd1);
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- On-chip instruction store that sits directly upstream of the instruction controller.
- The host loads 128-bit instructions as four 32-bit word writes.
- The controller fetches one instruction per request by PC, with fixed one-cycle latency.
- Also provides host read-back and write protection while the NPU runs, and flags fetches outside the loaded program.

Parameters:
- DEPTH, 4096, instruction lines stored (≤ 2^AW).
- AW, 12, PC / line address width.
- DW, 128, instruction width (fixed 4 x 32-bit lanes).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_host_wr_en  in  1  host word write strobe.
- i_host_addr  in  AW+2  {line, lane}; lane = addr[1:0].
- i_host_wdata  in  32  host write word.
- i_host_rd_en  in  1  host word read strobe (uses i_host_addr).
- o_host_rdata  out  32  read-back word.
- o_host_rvalid  out  1  read-back valid pulse.
- o_host_wr_err  out  1  one-cycle pulse on rejected or incomplete write.
- i_npu_idle  in  1  high when the NPU is idle; host access allowed only then.
- i_pc  in  AW  fetch address from controller.
- i_rd_en  in  1  fetch request.
- o_inst  out  DW  fetched instruction.
- o_inst_valid  out  1  fetch result valid.
- o_pc_err  out  1  fetch address invalid, qualified by o_inst_valid.
- o_loaded_lines  out  AW+1  highest committed line + 1.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - All outputs 0; staging lanes and lane mask cleared; o_loaded_lines=0; pending host read cleared.
  - RAM contents are not reset.
- Storage: simple dual-port RAM, one write port and one read port.
- Host write, accepted only when i_npu_idle=1:
  - Lanes 0-2 load staging[lane] and set mask[lane].
  - A lane-3 write commits {wdata, stg2, stg1, stg0} to RAM[line]; lane 0 occupies bits 31:0. Mask clears on commit.
  - Lane-3 commit with mask≠3'b111: commit still happens using the stale staging; o_host_wr_err pulses.
  - Write while i_npu_idle=0: discarded, staging untouched, o_host_wr_err pulses the next cycle.
  - Write with line ≥ DEPTH: discarded, err pulse.
  - On commit: o_loaded_lines <= max(o_loaded_lines, line+1).
- Fetch:
  - i_rd_en=1 at cycle N → o_inst/o_inst_valid/o_pc_err at N+1. Valid is a single-cycle pulse per request; back-to-back requests give back-to-back results.
  - pc ≥ DEPTH or pc ≥ o_loaded_lines: o_inst=0, o_pc_err=1, valid=1.
  - o_inst holds its last value when valid=0.
- Write/read collision: commit and fetch of the same line in the same cycle → the fetch returns the new data (write-first bypass).
- Host read:
  - Shares the RAM read port; fetch has priority.
  - Idle, no fetch: 1-cycle latency; o_host_rdata = lane of RAM[line]; o_host_rvalid pulses.
  - Colliding with i_rd_en: held pending, serviced the first cycle without a fetch. A new host read while one is pending is dropped.
  - i_npu_idle=0 or line ≥ DEPTH: returns 0 with rvalid the next cycle (never stalls the host).
- i_npu_idle falling while lanes are staged: staging is kept; the host resumes later.
- Reset mid-operation: pending read and any in-flight fetch result are lost; no valid pulses after reset.

Decomposition:
- Shared npu package holds:
  - INST_DW=128
  - INST_AW=12
  - INST_LANES=4
  - lane index constants
- Sub-module inst_ram_sdp: parameterised 1W1R synchronous RAM, registered read, no reset, for the memory macro swap.
- The remaining control stays in inst_buffer.

Test Plan:
- Idle; write lanes 0..3 of line 5 with 0x11111111, 0x22222222, 0x33333333, 0x44444444; fetch pc=5 → next cycle o_inst=0x44444444_33333333_22222222_11111111, valid=1, pc_err=0, o_loaded_lines=6.
- Load lines 0-3; fetch pc=0,1,2,3 back-to-back → four consecutive valid pulses, data in order; fetch pc=4 → o_inst=0, pc_err=1.
- i_npu_idle=0, write line 0 lane 0 → o_host_wr_err pulse; fetch 0 returns the old content. Lane-3 write after only lanes 0,1 staged → commit occurs, err pulse.
- Same-cycle lane-3 commit to line 7 and fetch pc=7 → fetched data equals the newly committed word.
- Host read of line 5 lane 2 in the same cycle as a fetch → host data 0x33333333 returned one cycle later than normal; fetch unaffected.
- Assert i_rst during a fetch and with 2 lanes staged → outputs 0 at once; after release, lane-3 write to line 0 flags err (mask cleared), o_loaded_lines=1.
